snd_scheduler: RTL and testbench
================================

Name: snd_scheduler

Overview:
- Arbitrates buzzer sound requests from several locker subsystems (keypad, door control, admin, error logic) onto the single buzzer player.
- Buffers one pending request per source and picks the next one by fixed priority.
- Drives the player's snd_sel/music trigger and times each sound's full playback from a per-code length table.
- Guarantees no sound is cut short, except by an optional higher-priority preemption.

Parameters:
- N_SRC, 4, number of requesters; index 0 = highest priority.
- GAP_MS, 30, silent gap in ms inserted between consecutive sounds.
- PREEMPT, 1, 1 = a pending request from a strictly higher-priority source aborts the current sound; 0 = never abort.

Ports:
- clk_in  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tick_1ms  in  1  one-cycle pulse every 1 ms, synchronous to clk_in.
- req  in  N_SRC  per-source request strobe, sampled each clk_in.
- req_code  in  4*N_SRC  sound code per source (source i at bits [4i+3:4i]), valid when req[i]=1.
- ack  out  N_SRC  one-cycle pulse when source i's request is latched into its pending slot.
- drop  out  N_SRC  one-cycle pulse when a new request from source i overwrites an unplayed pending one.
- snd_sel  out  4  code to the buzzer player.
- music  out  1  one-cycle playback trigger to the buzzer player.
- busy  out  1  high in SETUP, TRIG, PLAY and GAP.
- cur_src  out  log2(N_SRC)  source currently being played; valid while busy.

Behaviour:
- Reset (rst=0, async):
  - All pending slots are cleared.
  - State goes to IDLE.
  - snd_sel=4'hF (silent default code). music=0, busy=0, cur_src=0, ack=0, drop=0.
  - The ms counter is cleared.
- Request capture, every cycle, per source i:
  - If req[i]=1, the slot is loaded with req_code and ack[i] pulses on the next cycle.
  - If the slot was already occupied, it is overwritten and drop[i] pulses in the same cycle as ack[i]. Last request wins.
  - Codes 4'hF and any code with length 0 are acked and then discarded; no slot is set.
  - A request arriving in the same cycle as that source's slot is dispatched is kept as a new pending entry; it is not lost.
- Length table (ms), including a player safety margin:
  - codes 0-9: 125.
  - A: 375.
  - B: 1125.
  - C: 875.
  - D: 250.
  - E: 250.
  - others: 0.
- State machine:
  - IDLE: if any slot is pending, select the lowest index i. Load snd_sel, cur_src and the length. Clear slot i. Go to SETUP.
  - SETUP: hold for 1 cycle so snd_sel is stable before the trigger. Go to TRIG.
  - TRIG: music=1 for exactly one cycle. Clear the ms counter. Go to PLAY.
  - PLAY: count tick_1ms. When count == length, go to GAP and clear the counter. snd_sel is held for the whole of PLAY.
  - GAP: count tick_1ms to GAP_MS, then go to IDLE. snd_sel stays at the last code (the player is already silent).
- Latency: from a req pulse in IDLE to music=1 is 3 clk_in cycles (capture, select, SETUP).
- Preemption (PREEMPT=1), in PLAY or GAP:
  - Trigger: a pending slot j exists with j < cur_src.
  - The current sound is abandoned with no gap. Slot j is selected and the FSM goes directly to SETUP.
  - The abandoned request is not requeued.
  - Equal or lower priority never preempts.
- Counter width: 11 bits, saturating (max length 1125).
- tick_1ms coinciding with TRIG is not counted.
- Reset mid-PLAY forces IDLE immediately. The player is silenced at its next music-independent default via snd_sel=F.

Decomposition:
- Shared package snd_pkg holds:
  - sound code localparams: KEY0..KEY9=0-9, SND_CLEAR=A, SND_CLOSE=B, SND_OPEN=C, SND_DEL=D, SND_ERR=E, SND_NONE=F.
  - the per-code length constants.
  - the state encoding.
  The buzzer player uses the same code constants.
- One sub-module: snd_len_rom. Combinational code -> 11-bit ms length lookup, reused by both the scheduler and the verification model.

Test Plan:
- Single request: req[2]=1 with code C in IDLE -> ack[2] next cycle; music pulse at cycle +3 with snd_sel=C; busy high for 875 ticks + 30 ticks, then IDLE.
- Simultaneous requests: req[1]=code 5 and req[3]=code B in the same cycle -> code 5 plays first (125 ms + gap), then code B; cur_src shows 1 then 3.
- Overwrite while queued: source 3 requests 2 then 7 during another source's PLAY -> drop[3] pulses on the second request; only code 7 plays afterwards.
- Preemption: during code B PLAY for source 2, source 0 requests E -> within 2 cycles the FSM is in SETUP with snd_sel=E; B is never resumed. With PREEMPT=0, E plays only after B finishes plus the gap.
- Invalid and zero-length codes: a request with code F -> ack pulses, busy stays 0, no music pulse.
- Async reset at PLAY tick 400 of code C -> all outputs at reset values the same cycle; pending slots are empty after release.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared buzzer definitions: sound codes, per-code playback lengths and scheduler states.
// The buzzer player decodes the same code constants.
package snd_pkg;

    localparam int CNT_W = 11;

    localparam logic [3:0] KEY0      = 4'h0;
    localparam logic [3:0] KEY1      = 4'h1;
    localparam logic [3:0] KEY2      = 4'h2;
    localparam logic [3:0] KEY3      = 4'h3;
    localparam logic [3:0] KEY4      = 4'h4;
    localparam logic [3:0] KEY5      = 4'h5;
    localparam logic [3:0] KEY6      = 4'h6;
    localparam logic [3:0] KEY7      = 4'h7;
    localparam logic [3:0] KEY8      = 4'h8;
    localparam logic [3:0] KEY9      = 4'h9;
    localparam logic [3:0] SND_CLEAR = 4'hA;
    localparam logic [3:0] SND_CLOSE = 4'hB;
    localparam logic [3:0] SND_OPEN  = 4'hC;
    localparam logic [3:0] SND_DEL   = 4'hD;
    localparam logic [3:0] SND_ERR   = 4'hE;
    localparam logic [3:0] SND_NONE  = 4'hF;

    // Lengths in ms, already including the player's safety margin
    localparam logic [CNT_W-1:0] LEN_KEY   = 11'd125;
    localparam logic [CNT_W-1:0] LEN_CLEAR = 11'd375;
    localparam logic [CNT_W-1:0] LEN_CLOSE = 11'd1125;
    localparam logic [CNT_W-1:0] LEN_OPEN  = 11'd875;
    localparam logic [CNT_W-1:0] LEN_DEL   = 11'd250;
    localparam logic [CNT_W-1:0] LEN_ERR   = 11'd250;
    localparam logic [CNT_W-1:0] LEN_NONE  = 11'd0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_TRIG  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4
    } state_t;

endpackage

// File: rtl/snd_scheduler_if.sv
// Requester / player bus of the sound scheduler.
// master = requesting side and player, slave = scheduler.
interface snd_scheduler_if #(
    parameter int N_SRC = 4,
    parameter int SRC_W = 2
);
    logic [N_SRC-1:0]   req;
    logic [4*N_SRC-1:0] req_code;
    logic [N_SRC-1:0]   ack;
    logic [N_SRC-1:0]   drop;
    logic [3:0]         snd_sel;
    logic               music;
    logic               busy;
    logic [SRC_W-1:0]   cur_src;

    modport master (
        output req, req_code,
        input  ack, drop, snd_sel, music, busy, cur_src
    );

    modport slave (
        input  req, req_code,
        output ack, drop, snd_sel, music, busy, cur_src
    );
endinterface

// File: rtl/snd_len_rom.sv
// Sound code to playback length (ms) lookup; unknown codes map to zero length.
module snd_len_rom
    import snd_pkg::*;
(
    input  logic [3:0]       code,
    output logic [CNT_W-1:0] len
);

    always_comb begin
        len = LEN_NONE;
        case (code)
            KEY0, KEY1, KEY2, KEY3, KEY4,
            KEY5, KEY6, KEY7, KEY8, KEY9: len = LEN_KEY;
            SND_CLEAR:                    len = LEN_CLEAR;
            SND_CLOSE:                    len = LEN_CLOSE;
            SND_OPEN:                     len = LEN_OPEN;
            SND_DEL:                      len = LEN_DEL;
            SND_ERR:                      len = LEN_ERR;
            SND_NONE:                     len = LEN_NONE;
            default:                      len = LEN_NONE;
        endcase
    end

endmodule

// File: rtl/snd_scheduler.sv
// Fixed-priority buzzer request scheduler with one pending slot per source.
//   state | meaning
//   IDLE  | no sound; dispatch lowest-index pending slot
//   SETUP | snd_sel settling before the trigger
//   TRIG  | one-cycle music pulse, ms counter cleared
//   PLAY  | count ms up to the code length
//   GAP   | silent gap of GAP_MS before the next sound
module snd_scheduler
    import snd_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int GAP_MS  = 30,
    parameter int PREEMPT = 1
) (
    input logic           clk_in,
    input logic           rst,
    input logic           tick_1ms,
    snd_scheduler_if.slave bus
);

    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam logic [CNT_W-1:0] GAP_LEN = CNT_W'(GAP_MS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [N_SRC-1:0] slot_vld;
    logic [3:0]       slot_code [N_SRC];
    logic [CNT_W-1:0] slot_len  [N_SRC];
    logic [CNT_W-1:0] req_len   [N_SRC];
    logic [N_SRC-1:0] req_ok;
    logic [N_SRC-1:0] disp_oh;
    logic [N_SRC-1:0] ack_r, drop_r;

    logic             pend_any;
    logic [SRC_W-1:0] pend_idx;
    logic             preempt_hit, dispatch;
    logic [3:0]       sel_code;
    logic [CNT_W-1:0] sel_len;

    logic [CNT_W-1:0] len_r, cnt, cnt_inc;
    logic [3:0]       snd_sel_r;
    logic             music_r, busy_r;
    logic [SRC_W-1:0] cur_src_r;

    // Zero-length codes are acked but never occupy a slot
    for (genvar g = 0; g < N_SRC; g++) begin : g_req
        snd_len_rom u_len_rom (
            .code (bus.req_code[4*g +: 4]),
            .len  (req_len[g])
        );
        assign req_ok[g] = bus.req[g] && (req_len[g] != '0);
    end

    always_comb begin
        pend_any = 1'b0;
        pend_idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (slot_vld[i]) begin
                pend_any = 1'b1;
                pend_idx = SRC_W'(i);
            end
        end
    end

    assign preempt_hit = (PREEMPT != 0) && pend_any && (pend_idx < cur_src_r) &&
                         ((state == ST_PLAY) || (state == ST_GAP));
    assign dispatch    = ((state == ST_IDLE) && pend_any) || preempt_hit;
    assign disp_oh     = dispatch ? (N_SRC'(1) << pend_idx) : '0;
    assign sel_code    = slot_code[pend_idx];
    assign sel_len     = slot_len[pend_idx];
    assign cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // A request in the same cycle its slot is dispatched refills the slot
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            slot_vld <= '0;
            ack_r    <= '0;
            drop_r   <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                slot_code[i] <= SND_NONE;
                slot_len[i]  <= '0;
            end
        end else begin
            ack_r <= bus.req;
            for (int i = 0; i < N_SRC; i++) begin
                drop_r[i] <= req_ok[i] && slot_vld[i] && !disp_oh[i];
                if (req_ok[i]) begin
                    slot_vld[i]  <= 1'b1;
                    slot_code[i] <= bus.req_code[4*i +: 4];
                    slot_len[i]  <= req_len[i];
                end else if (disp_oh[i]) begin
                    slot_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            snd_sel_r <= SND_NONE;
            music_r   <= 1'b0;
            busy_r    <= 1'b0;
            cur_src_r <= '0;
            len_r     <= '0;
            cnt       <= '0;
        end else begin
            music_r <= 1'b0;
            if (dispatch) begin
                state     <= ST_SETUP;
                snd_sel_r <= sel_code;
                cur_src_r <= pend_idx;
                len_r     <= sel_len;
                busy_r    <= 1'b1;
                cnt       <= '0;
            end else begin
                case (state)
                    ST_SETUP: begin
                        state   <= ST_TRIG;
                        music_r <= 1'b1;
                    end
                    ST_TRIG: begin
                        state <= ST_PLAY;
                        cnt   <= '0;
                    end
                    ST_PLAY: begin
                        if (cnt == len_r) begin
                            state <= ST_GAP;
                            cnt   <= '0;
                        end else if (tick_1ms) begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_GAP: begin
                        if (cnt == GAP_LEN) begin
                            state  <= ST_IDLE;
                            busy_r <= 1'b0;
                        end else if (tick_1ms) begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_IDLE: begin
                        busy_r <= 1'b0;
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ack     = ack_r;
    assign bus.drop    = drop_r;
    assign bus.snd_sel = snd_sel_r;
    assign bus.music   = music_r;
    assign bus.busy    = busy_r;
    assign bus.cur_src = cur_src_r;

endmodule

// File: tb/tb_snd_scheduler.sv
// Directed bench: two schedulers (PREEMPT=1 and PREEMPT=0) driven in lockstep.
module tb_snd_scheduler;

    logic clk_in;
    logic rst;
    logic tick_1ms;
    int   checks = 0;
    int   errors = 0;
    int   mus_a  = 0;
    int   mus_b  = 0;
    int   m0;

    snd_scheduler_if #(.N_SRC(4), .SRC_W(2)) bus_a ();
    snd_scheduler_if #(.N_SRC(4), .SRC_W(2)) bus_b ();

    assign bus_b.req      = bus_a.req;
    assign bus_b.req_code = bus_a.req_code;

    snd_scheduler #(.N_SRC(4), .GAP_MS(30), .PREEMPT(1)) dut_a (
        .clk_in   (clk_in),
        .rst      (rst),
        .tick_1ms (tick_1ms),
        .bus      (bus_a)
    );

    snd_scheduler #(.N_SRC(4), .GAP_MS(30), .PREEMPT(0)) dut_b (
        .clk_in   (clk_in),
        .rst      (rst),
        .tick_1ms (tick_1ms),
        .bus      (bus_b)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_in);
        mus_a += int'(bus_a.music);
        mus_b += int'(bus_b.music);
    endtask

    task automatic tick_pulse(input int n);
        repeat (n) begin
            tick_1ms = 1'b1;
            cyc();
            tick_1ms = 1'b0;
            cyc();
        end
    endtask

    task automatic set_req(input int src, input logic [3:0] code);
        bus_a.req[src]            = 1'b1;
        bus_a.req_code[4*src +: 4] = code;
    endtask

    task automatic clr_req();
        bus_a.req = '0;
    endtask

    initial begin
        rst            = 1'b0;
        tick_1ms       = 1'b0;
        bus_a.req      = '0;
        bus_a.req_code = '0;
        cyc();
        cyc();
        chk("rst_snd_sel", 32'(bus_a.snd_sel), 32'hF);
        chk("rst_music",   32'(bus_a.music),   32'h0);
        chk("rst_busy",    32'(bus_a.busy),    32'h0);
        chk("rst_cur_src", 32'(bus_a.cur_src), 32'h0);
        chk("rst_ack",     32'(bus_a.ack),     32'h0);
        chk("rst_drop",    32'(bus_a.drop),    32'h0);
        rst = 1'b1;
        cyc();

        // single request, code C on source 2; a tick during TRIG is ignored
        m0 = mus_a;
        set_req(2, 4'hC);
        cyc();
        chk("single_ack",  32'(bus_a.ack),  32'b0100);
        chk("single_busy0", 32'(bus_a.busy), 32'h0);
        clr_req();
        cyc();
        chk("single_setup_busy", 32'(bus_a.busy),    32'h1);
        chk("single_setup_sel",  32'(bus_a.snd_sel), 32'hC);
        chk("single_setup_src",  32'(bus_a.cur_src), 32'h2);
        chk("single_setup_mus",  32'(bus_a.music),   32'h0);
        cyc();
        chk("single_trig_mus", 32'(bus_a.music), 32'h1);
        tick_1ms = 1'b1;
        cyc();
        tick_1ms = 1'b0;
        chk("single_play_mus", 32'(bus_a.music), 32'h0);
        tick_pulse(875);
        chk("single_875_busy", 32'(bus_a.busy),    32'h1);
        chk("single_875_sel",  32'(bus_a.snd_sel), 32'hC);
        tick_pulse(29);
        chk("single_gap29_busy", 32'(bus_a.busy), 32'h1);
        tick_pulse(1);
        chk("single_done_busy", 32'(bus_a.busy),    32'h0);
        chk("single_done_sel",  32'(bus_a.snd_sel), 32'hC);
        chk("single_mus_cnt",   32'(mus_a - m0),    32'd1);

        // simultaneous requests: source 1 (code 5) before source 3 (code B)
        set_req(1, 4'h5);
        set_req(3, 4'hB);
        cyc();
        chk("simul_ack",  32'(bus_a.ack),  32'b1010);
        chk("simul_drop", 32'(bus_a.drop), 32'h0);
        clr_req();
        cyc();
        chk("simul_first_src", 32'(bus_a.cur_src), 32'h1);
        chk("simul_first_sel", 32'(bus_a.snd_sel), 32'h5);
        cyc();
        cyc();
        tick_pulse(154);
        chk("simul_first_gap_busy", 32'(bus_a.busy), 32'h1);
        tick_pulse(1);
        chk("simul_between_busy", 32'(bus_a.busy), 32'h0);
        cyc();
        chk("simul_second_src", 32'(bus_a.cur_src), 32'h3);
        chk("simul_second_sel", 32'(bus_a.snd_sel), 32'hB);
        cyc();
        chk("simul_second_mus", 32'(bus_a.music), 32'h1);
        cyc();
        tick_pulse(1154);
        chk("simul_second_gap_busy", 32'(bus_a.busy), 32'h1);
        tick_pulse(1);
        chk("simul_second_done", 32'(bus_a.busy), 32'h0);

        // overwrite while queued: source 3 asks for 2 then 7 during source 0's sound
        set_req(0, 4'h1);
        cyc();
        clr_req();
        cyc();
        chk("ovw_play_src", 32'(bus_a.cur_src), 32'h0);
        cyc();
        cyc();
        tick_pulse(10);
        set_req(3, 4'h2);
        cyc();
        chk("ovw_first_ack",  32'(bus_a.ack),  32'b1000);
        chk("ovw_first_drop", 32'(bus_a.drop), 32'h0);
        clr_req();
        tick_pulse(10);
        set_req(3, 4'h7);
        cyc();
        chk("ovw_second_ack",  32'(bus_a.ack),  32'b1000);
        chk("ovw_second_drop", 32'(bus_a.drop), 32'b1000);
        clr_req();
        cyc();
        chk("ovw_drop_clear", 32'(bus_a.drop), 32'h0);
        tick_pulse(134);
        chk("ovw_src0_busy", 32'(bus_a.busy),    32'h1);
        chk("ovw_src0_sel",  32'(bus_a.snd_sel), 32'h1);
        tick_pulse(1);
        chk("ovw_src0_done", 32'(bus_a.busy), 32'h0);
        cyc();
        chk("ovw_src3_sel", 32'(bus_a.snd_sel), 32'h7);
        chk("ovw_src3_src", 32'(bus_a.cur_src), 32'h3);
        cyc();
        cyc();
        tick_pulse(155);
        cyc();
        cyc();
        chk("ovw_no_code2_busy", 32'(bus_a.busy),    32'h0);
        chk("ovw_no_code2_sel",  32'(bus_a.snd_sel), 32'h7);

        // request in the same cycle its slot is dispatched is kept
        set_req(2, 4'hD);
        cyc();
        set_req(2, 4'h3);
        cyc();
        chk("redisp_ack",  32'(bus_a.ack),     32'b0100);
        chk("redisp_drop", 32'(bus_a.drop),    32'h0);
        chk("redisp_sel",  32'(bus_a.snd_sel), 32'hD);
        clr_req();
        cyc();
        cyc();
        tick_pulse(279);
        chk("redisp_d_gap_busy", 32'(bus_a.busy), 32'h1);
        tick_pulse(1);
        chk("redisp_d_done", 32'(bus_a.busy), 32'h0);
        cyc();
        chk("redisp_next_busy", 32'(bus_a.busy),    32'h1);
        chk("redisp_next_sel",  32'(bus_a.snd_sel), 32'h3);
        cyc();
        cyc();
        tick_pulse(155);
        chk("redisp_all_done", 32'(bus_a.busy), 32'h0);

        // code F: acked, never played
        m0 = mus_a;
        set_req(1, 4'hF);
        cyc();
        chk("inv_ack",  32'(bus_a.ack),  32'b0010);
        chk("inv_drop", 32'(bus_a.drop), 32'h0);
        clr_req();
        repeat (4) cyc();
        chk("inv_busy", 32'(bus_a.busy),   32'h0);
        chk("inv_mus",  32'(mus_a - m0),   32'd0);

        // preemption of source 2 code B by source 0 code E
        m0 = mus_b;
        set_req(2, 4'hB);
        cyc();
        clr_req();
        cyc();
        chk("pre_b_src_a", 32'(bus_a.cur_src), 32'h2);
        chk("pre_b_src_b", 32'(bus_b.cur_src), 32'h2);
        cyc();
        cyc();
        tick_pulse(100);
        set_req(0, 4'hE);
        cyc();
        chk("pre_ack_a",     32'(bus_a.ack),     32'b0001);
        chk("pre_hold_sel_a", 32'(bus_a.snd_sel), 32'hB);
        clr_req();
        cyc();
        chk("pre_setup_sel_a",  32'(bus_a.snd_sel), 32'hE);
        chk("pre_setup_src_a",  32'(bus_a.cur_src), 32'h0);
        chk("pre_setup_busy_a", 32'(bus_a.busy),    32'h1);
        chk("nopre_sel_b",      32'(bus_b.snd_sel), 32'hB);
        chk("nopre_src_b",      32'(bus_b.cur_src), 32'h2);
        cyc();
        chk("pre_trig_mus_a",  32'(bus_a.music), 32'h1);
        chk("nopre_trig_mus_b", 32'(bus_b.music), 32'h0);
        cyc();
        tick_pulse(280);
        cyc();
        chk("pre_done_busy_a", 32'(bus_a.busy),    32'h0);
        chk("pre_done_sel_a",  32'(bus_a.snd_sel), 32'hE);
        chk("nopre_busy_b",    32'(bus_b.busy),    32'h1);
        chk("nopre_hold_sel_b", 32'(bus_b.snd_sel), 32'hB);
        tick_pulse(774);
        chk("nopre_gap_busy_b", 32'(bus_b.busy), 32'h1);
        tick_pulse(1);
        chk("nopre_b_done", 32'(bus_b.busy), 32'h0);
        chk("nopre_b_mus",  32'(mus_b - m0), 32'd1);
        cyc();
        chk("nopre_e_sel_b", 32'(bus_b.snd_sel), 32'hE);
        chk("nopre_e_src_b", 32'(bus_b.cur_src), 32'h0);
        cyc();
        chk("nopre_e_mus_b", 32'(bus_b.music), 32'h1);
        cyc();
        tick_pulse(280);
        chk("nopre_e_done_b", 32'(bus_b.busy), 32'h0);

        // async reset at tick 400 of code C, with source 3 pending
        set_req(2, 4'hC);
        cyc();
        clr_req();
        cyc();
        cyc();
        cyc();
        tick_pulse(400);
        set_req(3, 4'h4);
        cyc();
        chk("rstmid_ack", 32'(bus_a.ack), 32'b1000);
        clr_req();
        #2;
        rst = 1'b0;
        #1;
        chk("rstmid_busy",    32'(bus_a.busy),    32'h0);
        chk("rstmid_sel",     32'(bus_a.snd_sel), 32'hF);
        chk("rstmid_music",   32'(bus_a.music),   32'h0);
        chk("rstmid_cur_src", 32'(bus_a.cur_src), 32'h0);
        chk("rstmid_ack0",    32'(bus_a.ack),     32'h0);
        chk("rstmid_busy_b",  32'(bus_b.busy),    32'h0);
        @(negedge clk_in);
        rst = 1'b1;
        m0 = mus_a;
        repeat (4) cyc();
        chk("rstmid_slot_empty_a", 32'(bus_a.busy), 32'h0);
        chk("rstmid_slot_empty_b", 32'(bus_b.busy), 32'h0);
        chk("rstmid_no_music",     32'(mus_a - m0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
